mvu_input_transposer: RTL and testbench

//  Bit-plane transposer between pito_soc and MVU input RAM; one instance per MVU.

---
 rtl/mvu_input_transposer_pkg.sv | 16 +
 rtl/mvu_input_transposer_if.sv | 34 +++
 rtl/mvu_input_transposer.sv | 146 ++++++++++++++
 tb/tb_mvu_input_transposer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mvu_input_transposer_pkg.sv
// Shared types and default sizes for the MVU input bit-plane transposer.
package mvu_input_transposer_pkg;

  localparam int unsigned N         = 64;
  localparam int unsigned BDBANKA   = 15;
  localparam int unsigned BDBANKW   = 64;
  localparam int unsigned XPR_LEN   = 32;
  localparam int unsigned MAX_PREC  = 16;

  typedef enum logic [1:0] {
    TP_IDLE    = 2'd0,
    TP_COLLECT = 2'd1,
    TP_WRITE   = 2'd2
  } transposer_state_t;

endpackage

// File: rtl/mvu_input_transposer_if.sv
// Word-input and MVU write-port bundle between pito_soc side and one MVU.
interface mvu_input_transposer_if
  import mvu_input_transposer_pkg::*;
#(
  parameter int unsigned XLEN          = XPR_LEN,
  parameter int unsigned MVU_ADDR_LEN  = BDBANKA,
  parameter int unsigned MVU_DATA_LEN  = BDBANKW,
  parameter int unsigned MAX_DATA_PREC = MAX_PREC
) ();

  localparam int unsigned PREC_W = $clog2(MAX_DATA_PREC + 1);

  logic [PREC_W-1:0]       prec;
  logic [MVU_ADDR_LEN-1:0] baddr;
  logic                    start;
  logic                    iword_valid;
  logic [XLEN-1:0]         iword;
  logic                    busy;
  logic                    done;
  logic                    mvu_wr_en;
  logic [MVU_ADDR_LEN-1:0] mvu_wr_addr;
  logic [MVU_DATA_LEN-1:0] mvu_wr_word;

  modport master (
    output prec, baddr, start, iword_valid, iword,
    input  busy, done, mvu_wr_en, mvu_wr_addr, mvu_wr_word
  );

  modport slave (
    input  prec, baddr, start, iword_valid, iword,
    output busy, done, mvu_wr_en, mvu_wr_addr, mvu_wr_word
  );

endinterface

// File: rtl/mvu_input_transposer.sv
// Collects NUM_WORDS element words and re-emits them as prec bit-plane writes,
// MSB plane first, so the MVU reads bit b of every lane from one RAM word.
module mvu_input_transposer
  import mvu_input_transposer_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = N,
  parameter int unsigned XLEN          = XPR_LEN,
  parameter int unsigned MVU_ADDR_LEN  = BDBANKA,
  parameter int unsigned MVU_DATA_LEN  = BDBANKW,
  parameter int unsigned MAX_DATA_PREC = MAX_PREC
) (
  input logic                  clk,
  input logic                  rst,
  mvu_input_transposer_if.slave bus
);

  localparam int unsigned PREC_W = $clog2(MAX_DATA_PREC + 1);
  localparam int unsigned BIT_W  = $clog2(MAX_DATA_PREC);
  localparam int unsigned CNT_W  = $clog2(NUM_WORDS);

  transposer_state_t       state_q, state_d;
  logic [PREC_W-1:0]       prec_q, prec_d;
  logic [MVU_ADDR_LEN-1:0] baddr_q, baddr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PREC_W-1:0]       plane_q, plane_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wr_en_q, wr_en_d;
  logic [MVU_ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
  logic [MVU_DATA_LEN-1:0] wr_word_q, wr_word_d;

  logic [MAX_DATA_PREC-1:0] buf_q [NUM_WORDS];
  logic                     buf_we_c;
  logic [CNT_W-1:0]         buf_row_c;
  logic [PREC_W-1:0]        prec_in_c;
  logic [BIT_W-1:0]         bit_idx_c;
  logic                     unused_iword_c;

  // Upper iword bits are intentionally dropped.
  assign unused_iword_c = ^bus.iword;

  assign prec_in_c = (bus.prec > PREC_W'(MAX_DATA_PREC)) ? PREC_W'(MAX_DATA_PREC) : bus.prec;
  assign bit_idx_c = BIT_W'(prec_q - plane_q - PREC_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TP_IDLE;
      prec_q    <= '0;
      baddr_q   <= '0;
      cnt_q     <= '0;
      plane_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_word_q <= '0;
    end else begin
      state_q   <= state_d;
      prec_q    <= prec_d;
      baddr_q   <= baddr_d;
      cnt_q     <= cnt_d;
      plane_q   <= plane_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_word_q <= wr_word_d;
    end
  end

  // Bit buffer: one row written per accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_WORDS); k++) begin
        buf_q[k] <= '0;
      end
    end else if (buf_we_c) begin
      buf_q[buf_row_c] <= bus.iword[MAX_DATA_PREC-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    prec_d    = prec_q;
    baddr_d   = baddr_q;
    cnt_d     = cnt_q;
    plane_d   = plane_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_word_d = wr_word_q;
    buf_we_c  = 1'b0;
    buf_row_c = cnt_q;

    unique case (state_q)
      TP_IDLE: begin
        if (bus.start && (bus.prec != '0)) begin
          prec_d    = prec_in_c;
          baddr_d   = bus.baddr;
          buf_we_c  = 1'b1;
          buf_row_c = '0;
          cnt_d     = CNT_W'(1);
          busy_d    = 1'b1;
          state_d   = TP_COLLECT;
        end
      end
      TP_COLLECT: begin
        if (bus.iword_valid) begin
          buf_we_c = 1'b1;
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            plane_d = '0;
            state_d = TP_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      TP_WRITE: begin
        // plane_q == prec_q is the extra cycle that clears wr_en and busy.
        if (plane_q != prec_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = baddr_q + MVU_ADDR_LEN'(plane_q);
          for (int k = 0; k < int'(NUM_WORDS); k++) begin
            wr_word_d[k] = buf_q[k][bit_idx_c];
          end
          done_d  = (plane_q == (prec_q - PREC_W'(1)));
          plane_d = plane_q + PREC_W'(1);
        end else begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          plane_d = '0;
          state_d = TP_IDLE;
        end
      end
      default: state_d = TP_IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mvu_wr_en   = wr_en_q;
  assign bus.mvu_wr_addr = wr_addr_q;
  assign bus.mvu_wr_word = wr_word_q;

endmodule

// File: tb/tb_mvu_input_transposer.sv
// Directed self-checking bench for mvu_input_transposer.
module tb_mvu_input_transposer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mvu_input_transposer_if bus ();

  mvu_input_transposer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Element word k for stimulus pattern pat.
  function automatic logic [31:0] word_of(input int pat, input int k);
    case (pat)
      0:       return 32'(k % 4);
      1:       return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFE;
    endcase
  endfunction

  // Hand-derived bit-plane b of all 64 lanes for pattern pat.
  function automatic logic [63:0] plane_of(input int pat, input int b);
    case (pat)
      0:       return (b == 0) ? {16{4'hA}} : (b == 1) ? {16{4'hC}} : 64'h0;
      1:       return (b < 16) ? {64{1'b1}} : 64'h0;
      default: return (b == 0) ? 64'h0 : {64{1'b1}};
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " busy"},  64'(bus.busy), 64'h0);
    check({tag, " wr_en"}, 64'(bus.mvu_wr_en), 64'h0);
    check({tag, " done"},  64'(bus.done), 64'h0);
  endtask

  task automatic do_block(input int tid, input logic [4:0] prec_in, input logic [14:0] baddr_in,
                          input int pat, input bit gap, input bit midstart,
                          input int eff_prec, input int abort_at);
    logic [14:0] ea;
    bus.start       = 1'b1;
    bus.prec        = prec_in;
    bus.baddr       = baddr_in;
    bus.iword       = word_of(pat, 0);
    bus.iword_valid = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.iword_valid = 1'b0;
    check($sformatf("t%0d busy after start", tid), 64'(bus.busy), 64'h1);
    for (int k = 1; k < 64; k++) begin
      if (gap) begin
        bus.iword_valid = 1'b0;
        bus.iword       = 32'hDEAD_BEEF;
        tick();
        if (k == 1 || k == 63)
          check($sformatf("t%0d busy in stall %0d", tid, k), 64'(bus.busy), 64'h1);
      end
      bus.iword_valid = 1'b1;
      bus.iword       = word_of(pat, k);
      bus.prec        = 5'd3;
      bus.baddr       = 15'h7AAA;
      if (midstart && k == 30) begin
        bus.start = 1'b1;
        bus.baddr = 15'h0300;
        bus.prec  = 5'd2;
      end
      tick();
      bus.start = 1'b0;
    end
    bus.iword_valid = 1'b0;
    check($sformatf("t%0d wr_en after last word", tid), 64'(bus.mvu_wr_en), 64'h0);
    check($sformatf("t%0d busy after last word", tid), 64'(bus.busy), 64'h1);
    for (int i = 0; i < eff_prec; i++) begin
      tick();
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check($sformatf("t%0d rst wr_en", tid), 64'(bus.mvu_wr_en), 64'h0);
        check($sformatf("t%0d rst busy", tid), 64'(bus.busy), 64'h0);
        check($sformatf("t%0d rst addr", tid), 64'(bus.mvu_wr_addr), 64'h0);
        check($sformatf("t%0d rst word", tid), bus.mvu_wr_word, 64'h0);
        return;
      end
      ea = baddr_in + 15'(i);
      check($sformatf("t%0d wr_en[%0d]", tid, i), 64'(bus.mvu_wr_en), 64'h1);
      check($sformatf("t%0d wr_addr[%0d]", tid, i), 64'(bus.mvu_wr_addr), 64'(ea));
      check($sformatf("t%0d wr_word[%0d]", tid, i), bus.mvu_wr_word, plane_of(pat, eff_prec - 1 - i));
      check($sformatf("t%0d done[%0d]", tid, i), 64'(bus.done), 64'(i == eff_prec - 1));
      check($sformatf("t%0d busy[%0d]", tid, i), 64'(bus.busy), 64'h1);
    end
    tick();
    check_idle($sformatf("t%0d after block", tid));
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.iword_valid = 1'b0;
    bus.prec        = '0;
    bus.baddr       = '0;
    bus.iword       = '0;
    #12;
    check_idle("reset");
    check("reset addr", 64'(bus.mvu_wr_addr), 64'h0);
    check("reset word", bus.mvu_wr_word, 64'h0);
    rst = 1'b0;
    tick();

    // prec=2, words k%4: planes C then A
    do_block(1, 5'd2, 15'h0010, 0, 1'b0, 1'b0, 2, -1);
    // prec=16, all ones, address wrap from 0x7FFF
    do_block(2, 5'd16, 15'h7FFF, 1, 1'b0, 1'b0, 16, -1);
    // prec=1 with stalls, bit0 of 0xFFFFFFFE is zero
    do_block(3, 5'd1, 15'h0020, 2, 1'b1, 1'b0, 1, -1);
    // start mid-collect ignored; original baddr/prec used
    do_block(4, 5'd4, 15'h0200, 0, 1'b0, 1'b1, 4, -1);
    // reset on 3rd write of a prec=8 block
    do_block(5, 5'd8, 15'h0100, 1, 1'b0, 1'b0, 8, 2);
    tick();
    rst = 1'b0;
    tick();
    check_idle("t5 post reset");
    do_block(5, 5'd1, 15'h0055, 0, 1'b0, 1'b0, 1, -1);

    // prec=0 start ignored, then stray iword_valid in IDLE ignored
    bus.start       = 1'b1;
    bus.prec        = 5'd0;
    bus.baddr       = 15'h0033;
    bus.iword_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    check_idle("t6 prec0");
    tick();
    check_idle("t6 stray valid");
    bus.iword_valid = 1'b0;
    // prec=20 clamps to 16
    do_block(6, 5'd20, 15'h0040, 1, 1'b0, 1'b0, 16, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
